// File: rtl/row_packer_8to64_if.sv
//------------------------------------------------------------------------------
// row_packer_8to64_if : pixel-in / packed-word-out bus of the row packer
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface row_packer_8to64_if #(
  parameter int DATA_W       = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 8
);
  localparam int WORD_W = DATA_W * PIX_PER_WORD;

  logic              Start;
  logic [ADDR_W-1:0] base_addr;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_valid;
  logic              pixel_last;
  logic              pixel_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [WORD_W-1:0] dina;
  logic [3:0]        byte_cnt;
  logic              out_valid;
  logic              out_ready;
  logic              row_done;
  logic [15:0]       word_count;

  modport slave (
    input  Start, base_addr, pixel_data, pixel_valid, pixel_last, out_ready,
    output pixel_ready, ena, wea, addra, dina, byte_cnt, out_valid, row_done, word_count
  );

  modport master (
    output Start, base_addr, pixel_data, pixel_valid, pixel_last, out_ready,
    input  pixel_ready, ena, wea, addra, dina, byte_cnt, out_valid, row_done, word_count
  );
endinterface

`default_nettype wire

// File: rtl/row_packer_8to64.sv
//------------------------------------------------------------------------------
// row_packer_8to64 : packs 8-bit pixels LSB-first into 64-bit BRAM write words
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module row_packer_8to64 #(
  parameter int DATA_W       = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int ADDR_W       = 8
) (
  input  wire logic         clk,
  input  wire logic         reset,
  row_packer_8to64_if.slave bus
);

  localparam int         WORD_W    = DATA_W * PIX_PER_WORD;
  localparam logic [3:0] LAST_SLOT = 4'(PIX_PER_WORD - 1);

  logic [WORD_W-1:0] acc_q,        acc_d;
  logic [3:0]        fill_q,       fill_d;
  logic              out_valid_q,  out_valid_d;
  logic [WORD_W-1:0] dina_q,       dina_d;
  logic [3:0]        byte_cnt_q,   byte_cnt_d;
  logic              out_last_q,   out_last_d;
  logic [ADDR_W-1:0] addra_q,      addra_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              row_done_q,   row_done_d;

  logic              w_clear;
  logic              w_pix_ready;
  logic              w_pix_acc;
  logic              w_word_acc;
  logic              w_emit;
  logic [3:0]        w_fill_inc;
  logic [WORD_W-1:0] w_merged;
  logic [WORD_W-1:0] w_packed;

  // Reset and Start both squash the handshakes so nothing is taken or written
  assign w_clear     = reset | bus.Start;
  assign w_pix_ready = ~w_clear & (~out_valid_q | bus.out_ready);
  assign w_pix_acc   = bus.pixel_valid & w_pix_ready;
  assign w_word_acc  = ~w_clear & out_valid_q & bus.out_ready;
  assign w_fill_inc  = fill_q + 4'd1;
  assign w_emit      = w_pix_acc & ((fill_q == LAST_SLOT) | bus.pixel_last);

  for (genvar l = 0; l < PIX_PER_WORD; l++) begin : g_lane
    localparam logic [3:0] C_LANE = 4'(l);
    assign w_merged[l*DATA_W +: DATA_W] = (fill_q == C_LANE) ? bus.pixel_data
                                                             : acc_q[l*DATA_W +: DATA_W];
    assign w_packed[l*DATA_W +: DATA_W] = (C_LANE < w_fill_inc) ? w_merged[l*DATA_W +: DATA_W]
                                                                : '0;
  end

  always_comb begin
    acc_d        = acc_q;
    fill_d       = fill_q;
    out_valid_d  = out_valid_q;
    dina_d       = dina_q;
    byte_cnt_d   = byte_cnt_q;
    out_last_d   = out_last_q;
    addra_d      = addra_q;
    word_count_d = word_count_q;
    row_done_d   = 1'b0;

    if (bus.Start) begin
      acc_d        = '0;
      fill_d       = '0;
      out_valid_d  = 1'b0;
      dina_d       = '0;
      byte_cnt_d   = '0;
      out_last_d   = 1'b0;
      addra_d      = bus.base_addr;
      word_count_d = '0;
    end else begin
      row_done_d = w_word_acc & out_last_q;

      if (w_word_acc) begin
        addra_d      = addra_q + 1'b1;
        word_count_d = word_count_q + 16'd1;
        out_valid_d  = 1'b0;
      end

      // An emit in the accept cycle reloads the out register: back-to-back words
      if (w_pix_acc) begin
        if (w_emit) begin
          acc_d       = '0;
          fill_d      = '0;
          out_valid_d = 1'b1;
          dina_d      = w_packed;
          byte_cnt_d  = w_fill_inc;
          out_last_d  = bus.pixel_last;
        end else begin
          acc_d  = w_merged;
          fill_d = w_fill_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      fill_q       <= '0;
      out_valid_q  <= 1'b0;
      dina_q       <= '0;
      byte_cnt_q   <= '0;
      out_last_q   <= 1'b0;
      addra_q      <= '0;
      word_count_q <= '0;
      row_done_q   <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      out_valid_q  <= out_valid_d;
      dina_q       <= dina_d;
      byte_cnt_q   <= byte_cnt_d;
      out_last_q   <= out_last_d;
      addra_q      <= addra_d;
      word_count_q <= word_count_d;
      row_done_q   <= row_done_d;
    end
  end

  assign bus.pixel_ready = w_pix_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.ena         = out_valid_q;
  assign bus.wea         = w_word_acc;
  assign bus.addra       = addra_q;
  assign bus.dina        = dina_q;
  assign bus.byte_cnt    = byte_cnt_q;
  assign bus.row_done    = row_done_q;
  assign bus.word_count  = word_count_q;

endmodule

`default_nettype wire

// File: tb/tb_row_packer_8to64.sv
//------------------------------------------------------------------------------
// tb_row_packer_8to64 : scoreboard bench, rows chunked into expected words
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_row_packer_8to64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  row_packer_8to64_if #(.DATA_W(8), .PIX_PER_WORD(8), .ADDR_W(8)) bus ();

  row_packer_8to64 #(.DATA_W(8), .PIX_PER_WORD(8), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  addr;
    logic [63:0] data;
    logic [3:0]  cnt;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] row_q[$];
  logic [7:0] addr_m;
  int         total = 0;
  int         bad = 0;
  int         ready_mode = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endfunction

  // out_ready: 0 = always high, 1 = random, 2 = held low
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each write, checks hold and row_done timing
  initial begin
    logic        exp_rd;
    logic        hold;
    logic [7:0]  h_addr;
    logic [63:0] h_data;
    int          wc;
    exp_t        e;
    exp_rd = 1'b0; hold = 1'b0; wc = 0; h_addr = '0; h_data = '0;
    forever begin
      @(negedge clk);
      if (reset || bus.Start) begin
        chk("ready_low_in_clear", {63'd0, bus.pixel_ready}, 64'd0);
        chk("no_wea_in_clear", {63'd0, bus.wea}, 64'd0);
        wc = 0; exp_rd = 1'b0; hold = 1'b0;
        continue;
      end
      chk("pixel_ready", {63'd0, bus.pixel_ready}, {63'd0, (~bus.ena | bus.out_ready)});
      if (hold)
        chk("hold_stable", {bus.addra, bus.dina[55:0]}, {h_addr, h_data[55:0]});
      if (exp_rd || bus.row_done)
        chk("row_done", {63'd0, bus.row_done}, {63'd0, exp_rd});
      exp_rd = 1'b0;
      if (bus.wea) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: addra %h dina %h with empty scoreboard", bus.addra, bus.dina);
        end else begin
          e = exp_q.pop_front();
          chk("addra", {56'd0, bus.addra}, {56'd0, e.addr});
          chk("dina", bus.dina, e.data);
          chk("byte_cnt", {60'd0, bus.byte_cnt}, {60'd0, e.cnt});
          chk("word_count", {48'd0, bus.word_count}, 64'(wc));
          exp_rd = e.last;
        end
        wc++;
      end
      hold   = bus.ena && !bus.out_ready;
      h_addr = bus.addra;
      h_data = bus.dina;
    end
  end

  task automatic push_row_expect();
    exp_t e;
    for (int i = 0; i < row_q.size(); i += 8) begin
      e.data = '0;
      e.cnt  = '0;
      for (int k = 0; k < 8; k++) begin
        if (i + k < row_q.size()) begin
          e.data[8*k +: 8] = row_q[i+k];
          e.cnt = e.cnt + 4'd1;
        end
      end
      e.addr = addr_m;
      e.last = (i + 8 >= row_q.size());
      addr_m = addr_m + 8'd1;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_pix(input logic [7:0] d, input logic last, input bit gaps);
    int   n;
    logic took;
    n = 0; took = 1'b0;
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = d;
    bus.pixel_last  = last;
    while (!took) begin
      @(negedge clk);
      took = bus.pixel_ready;
      @(posedge clk);
      #1;
      n++;
      if (!took && n > 200) begin
        total++; bad++;
        $display("FAIL pixel_accept_timeout: pixel %h not taken after %0d cycles", d, n);
        took = 1'b1;
      end
    end
    bus.pixel_valid = 1'b0;
    bus.pixel_last  = 1'b0;
    bus.pixel_data  = 8'($urandom);
    if (gaps && $urandom_range(0, 3) == 0)
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
  endtask

  task automatic drive_row(input bit complete, input bit gaps);
    if (complete) push_row_expect();
    for (int i = 0; i < row_q.size(); i++)
      send_pix(row_q[i], complete && (i == row_q.size() - 1), gaps);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.ena) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d words still expected", exp_q.size());
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic do_start(input logic [7:0] base);
    wait_idle();
    bus.Start     = 1'b1;
    bus.base_addr = base;
    @(posedge clk); #1;
    bus.Start     = 1'b0;
    bus.base_addr = 8'($urandom);
    addr_m        = base;
    exp_q.delete();
  endtask

  task automatic fill_row(input int len, input logic [7:0] first, input bit rnd);
    row_q.delete();
    for (int i = 0; i < len; i++)
      row_q.push_back(rnd ? 8'($urandom) : 8'(first + 8'(i)));
  endtask

  initial begin
    reset = 1'b1;
    bus.Start = 1'b0; bus.base_addr = '0;
    bus.pixel_valid = 1'b0; bus.pixel_last = 1'b0; bus.pixel_data = '0;
    addr_m = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ena", {63'd0, bus.ena}, 64'd0);
    chk("rst_addra", {56'd0, bus.addra}, 64'd0);
    chk("rst_dina", bus.dina, 64'd0);
    chk("rst_byte_cnt", {60'd0, bus.byte_cnt}, 64'd0);
    chk("rst_word_count", {48'd0, bus.word_count}, 64'd0);
    chk("rst_row_done", {63'd0, bus.row_done}, 64'd0);
    @(posedge clk); #1;

    // 16 pixels at base 0x10
    do_start(8'h10);
    fill_row(16, 8'h01, 1'b0);
    drive_row(1'b1, 1'b0);
    wait_idle();
    chk("word_count_after_16", {48'd0, bus.word_count}, 64'd2);

    // 11-pixel row ending on a partial word
    fill_row(11, 8'hA0, 1'b0);
    drive_row(1'b1, 1'b0);

    // Downstream stall right after the first emit
    wait_idle();
    ready_mode = 2;
    fork
      begin repeat (14) @(posedge clk); #1; ready_mode = 0; end
    join_none
    fill_row(13, 8'h30, 1'b0);
    drive_row(1'b1, 1'b0);

    // Start after 5 pixels discards them
    do_start(8'h40);
    fill_row(5, 8'h00, 1'b1);
    drive_row(1'b0, 1'b0);
    do_start(8'h50);
    fill_row(10, 8'h00, 1'b1);
    drive_row(1'b1, 1'b0);

    // Address wrap
    do_start(8'hFF);
    fill_row(16, 8'h00, 1'b1);
    drive_row(1'b1, 1'b0);

    // Random rows with random backpressure, gaps and occasional aborts
    wait_idle();
    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        fill_row(int'($urandom_range(1, 7)), 8'h00, 1'b1);
        drive_row(1'b0, 1'b1);
        do_start(8'($urandom));
      end
      fill_row(int'($urandom_range(1, 20)), 8'h00, 1'b1);
      drive_row(1'b1, 1'b1);
    end

    // Reset with a word pending in the out register
    wait_idle();
    ready_mode = 2;
    @(posedge clk); #1;
    fill_row(8, 8'hC0, 1'b0);
    drive_row(1'b1, 1'b0);
    chk("pending_before_reset", {63'd0, bus.ena}, 64'd1);
    reset = 1'b1;
    ready_mode = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    addr_m = '0;
    @(negedge clk);
    chk("post_rst_ena", {63'd0, bus.ena}, 64'd0);
    chk("post_rst_addra", {56'd0, bus.addra}, 64'd0);
    chk("post_rst_dina", bus.dina, 64'd0);
    chk("post_rst_byte_cnt", {60'd0, bus.byte_cnt}, 64'd0);
    chk("post_rst_word_count", {48'd0, bus.word_count}, 64'd0);
    @(posedge clk); #1;
    fill_row(9, 8'h00, 1'b1);
    drive_row(1'b1, 1'b0);
    wait_idle();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
